// File: rtl/uart_echo_fifo.sv
// UART echo engine: edge-detects receiver completion, buffers words in a FIFO
// and drains them to the transmitter with a busy handshake and timeout.
module uart_echo_fifo #(
    parameter int DATA_W       = 8,
    parameter int DEPTH        = 16,
    parameter int BUSY_TIMEOUT = 64
) (
    input  logic                      sys_clk,
    input  logic                      sys_rst_n,
    input  logic                      recv_done,
    input  logic [DATA_W-1:0]         recv_data,
    input  logic                      tx_busy,
    input  logic                      echo_en,
    input  logic                      flush,
    input  logic                      clr_status,
    output logic                      send_en,
    output logic [DATA_W-1:0]         send_data,
    output logic [$clog2(DEPTH):0]    fifo_level,
    output logic                      overflow,
    output logic                      tx_timeout
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int CW = $clog2(BUSY_TIMEOUT);

    localparam logic [1:0] S_IDLE      = 2'd0;
    localparam logic [1:0] S_START     = 2'd1;
    localparam logic [1:0] S_WAIT_BUSY = 2'd2;
    localparam logic [1:0] S_WAIT_IDLE = 2'd3;

    logic              d0_q, d1_q;
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]     level_q, level_d;
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [1:0]        state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              send_en_q, send_en_d;
    logic [DATA_W-1:0] send_data_q, send_data_d;
    logic              ovf_q, ovf_d, tmo_q, tmo_d;
    logic              push_req_s, push_try_s, push_s, pop_s, drop_s, tmo_set_s;

    assign push_req_s = d0_q & ~d1_q;
    assign push_try_s = push_req_s & echo_en & ~flush;
    assign pop_s      = (state_q == S_IDLE) && (level_q != '0) && !tx_busy && !flush;
    // A full FIFO still accepts a word when the head leaves in the same cycle.
    assign push_s     = push_try_s && ((level_q != LW'(DEPTH)) || pop_s);
    assign drop_s     = push_try_s && !push_s;

    // FIFO pointer and occupancy next-state.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (push_s) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (pop_s) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            case ({push_s, pop_s})
                2'b10:   level_d = level_q + LW'(1);
                2'b01:   level_d = level_q - LW'(1);
                default: level_d = level_q;
            endcase
        end
    end

    // Transmit handshake FSM next-state.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        send_data_d = send_data_q;
        tmo_set_s   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (pop_s) begin
                    state_d     = S_START;
                    send_data_d = mem_q[rd_ptr_q];
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_START: begin
                cnt_d   = '0;
                state_d = S_WAIT_BUSY;
            end
            S_WAIT_BUSY: begin
                if (tx_busy) begin
                    state_d = S_WAIT_IDLE;
                end else if (cnt_q == CW'(BUSY_TIMEOUT - 1)) begin
                    tmo_set_s = 1'b1;
                    state_d   = S_IDLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_WAIT_IDLE: begin
                if (!tx_busy) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_WAIT_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        send_en_d = (state_d == S_START);
    end

    // Sticky status: a new event wins over a clear in the same cycle.
    always_comb begin
        if (drop_s) begin
            ovf_d = 1'b1;
        end else if (clr_status) begin
            ovf_d = 1'b0;
        end else begin
            ovf_d = ovf_q;
        end
        if (tmo_set_s) begin
            tmo_d = 1'b1;
        end else if (clr_status) begin
            tmo_d = 1'b0;
        end else begin
            tmo_d = tmo_q;
        end
    end

    // State, pointer, flag and output registers.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            d0_q        <= 1'b0;
            d1_q        <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            send_en_q   <= 1'b0;
            send_data_q <= '0;
            ovf_q       <= 1'b0;
            tmo_q       <= 1'b0;
        end else begin
            d0_q        <= recv_done;
            d1_q        <= d0_q;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            send_en_q   <= send_en_d;
            send_data_q <= send_data_d;
            ovf_q       <= ovf_d;
            tmo_q       <= tmo_d;
        end
    end

    // FIFO storage write port; contents are not reset.
    always_ff @(posedge sys_clk) begin
        if (push_s) begin
            mem_q[wr_ptr_q] <= recv_data;
        end
    end

    assign send_en    = send_en_q;
    assign send_data  = send_data_q;
    assign fifo_level = level_q;
    assign overflow   = ovf_q;
    assign tx_timeout = tmo_q;

endmodule

// File: tb/tb_uart_echo_fifo.sv
// Self-checking bench for uart_echo_fifo: directed scenarios plus randomized
// echo traffic compared against an in-order word queue.
module tb_uart_echo_fifo;
    localparam int DW    = 8;
    localparam int DEPTH = 16;
    localparam int BT    = 64;

    logic          sys_clk    = 1'b0;
    logic          sys_rst_n  = 1'b0;
    logic          recv_done  = 1'b0;
    logic [DW-1:0] recv_data  = '0;
    logic          echo_en    = 1'b0;
    logic          flush      = 1'b0;
    logic          clr_status = 1'b0;
    logic          tx_force   = 1'b0;
    logic          tx_auto    = 1'b0;
    logic          model_busy = 1'b0;
    logic          tx_busy;
    logic          send_en;
    logic [DW-1:0] send_data;
    logic [4:0]    fifo_level;
    logic          overflow;
    logic          tx_timeout;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int pulse_cnt = 0;
    int last_pulse = -100;
    int pulse_cyc = 0;
    int busy_len = 10;
    int tx_dly = 0;
    int tx_left = 0;
    logic [DW-1:0] sent_q[$];

    assign tx_busy = tx_force | model_busy;

    uart_echo_fifo #(.DATA_W(DW), .DEPTH(DEPTH), .BUSY_TIMEOUT(BT)) dut (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .recv_done(recv_done),
        .recv_data(recv_data), .tx_busy(tx_busy), .echo_en(echo_en),
        .flush(flush), .clr_status(clr_status), .send_en(send_en),
        .send_data(send_data), .fifo_level(fifo_level), .overflow(overflow),
        .tx_timeout(tx_timeout)
    );

    always #5 sys_clk = ~sys_clk;

    always @(posedge sys_clk) cyc <= cyc + 1;

    // Records every send_en pulse and checks the minimum pulse spacing.
    always @(negedge sys_clk) begin
        if (send_en === 1'b1) begin
            checks++;
            if (cyc - last_pulse < 4) begin
                errors++;
                $display("FAIL pulse_spacing: gap %0d cycles, required >= 4", cyc - last_pulse);
            end
            last_pulse = cyc;
            pulse_cyc  = cyc;
            pulse_cnt++;
            sent_q.push_back(send_data);
        end
    end

    // Transmitter model: busy rises 2 cycles after send_en, lasts busy_len cycles.
    always @(negedge sys_clk) begin
        if (!tx_auto) begin
            tx_dly = 0; tx_left = 0; model_busy = 1'b0;
        end else if (send_en === 1'b1) begin
            tx_dly = 2;
        end else if (tx_dly > 0) begin
            tx_dly--;
            if (tx_dly == 0) begin
                model_busy = 1'b1;
                tx_left = busy_len;
            end
        end else if (model_busy) begin
            tx_left--;
            if (tx_left <= 0) model_busy = 1'b0;
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge sys_clk);
            #1;
        end
    endtask

    task automatic do_reset();
        sys_rst_n = 1'b0; recv_done = 1'b0; echo_en = 1'b1; flush = 1'b0;
        clr_status = 1'b0; tx_force = 1'b0; tx_auto = 1'b0;
        tick(2);
        sys_rst_n = 1'b1;
        tick(1);
        sent_q.delete();
        pulse_cnt = 0;
    endtask

    task automatic push_word(input logic [DW-1:0] d, input int hold);
        recv_data = d;
        recv_done = 1'b1;
        tick(hold);
        recv_done = 1'b0;
        tick(1);
    endtask

    task automatic wait_pulses(input int n, input int bound, input string name);
        int k = 0;
        while (pulse_cnt < n && k < bound) begin
            tick(1);
            k++;
        end
        checks++;
        if (pulse_cnt < n) begin
            errors++;
            $display("FAIL %s_wait: got %0d pulses, required %0d within %0d cycles", name, pulse_cnt, n, bound);
        end
    endtask

    task automatic test_reset();
        sys_rst_n = 1'b0;
        tick(2);
        checks += 5;
        if (send_en !== 1'b0) begin errors++; $display("FAIL reset_send_en: got %b, required 0", send_en); end
        if (send_data !== 8'h00) begin errors++; $display("FAIL reset_send_data: got %h, required 00", send_data); end
        if (fifo_level !== 5'd0) begin errors++; $display("FAIL reset_level: got %0d, required 0", fifo_level); end
        if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %b, required 0", overflow); end
        if (tx_timeout !== 1'b0) begin errors++; $display("FAIL reset_timeout: got %b, required 0", tx_timeout); end
    endtask

    task automatic test_single_echo();
        do_reset();
        tx_auto = 1'b1; busy_len = 10;
        push_word(8'hA5, 3);
        wait_pulses(1, 50, "single");
        tick(20);
        checks += 5;
        if (pulse_cnt !== 1) begin errors++; $display("FAIL single_pulses: got %0d, required 1", pulse_cnt); end
        if (sent_q.size() < 1 || sent_q[0] !== 8'hA5) begin errors++; $display("FAIL single_data: got %h, required a5", send_data); end
        if (fifo_level !== 5'd0) begin errors++; $display("FAIL single_level: got %0d, required 0", fifo_level); end
        if (overflow !== 1'b0) begin errors++; $display("FAIL single_overflow: got %b, required 0", overflow); end
        if (tx_timeout !== 1'b0) begin errors++; $display("FAIL single_timeout: got %b, required 0", tx_timeout); end
    endtask

    task automatic test_burst_full();
        do_reset();
        tx_force = 1'b1;
        for (int i = 0; i < 17; i++) push_word(DW'(i), 1);
        tick(2);
        checks += 3;
        if (fifo_level !== 5'd16) begin errors++; $display("FAIL burst_level: got %0d, required 16", fifo_level); end
        if (overflow !== 1'b1) begin errors++; $display("FAIL burst_overflow: got %b, required 1", overflow); end
        if (pulse_cnt !== 0) begin errors++; $display("FAIL burst_early_pulse: got %0d, required 0", pulse_cnt); end
        tx_force = 1'b0; tx_auto = 1'b1; busy_len = 3;
        wait_pulses(16, 400, "burst");
        tick(20);
        checks += 2;
        if (pulse_cnt !== 16) begin errors++; $display("FAIL burst_pulses: got %0d, required 16", pulse_cnt); end
        if (fifo_level !== 5'd0) begin errors++; $display("FAIL burst_drain_level: got %0d, required 0", fifo_level); end
        for (int i = 0; i < 16 && i < sent_q.size(); i++) begin
            checks++;
            if (sent_q[i] !== DW'(i)) begin errors++; $display("FAIL burst_order[%0d]: got %h, required %h", i, sent_q[i], DW'(i)); end
        end
    endtask

    task automatic test_full_pop();
        do_reset();
        tx_force = 1'b1;
        for (int i = 0; i < 16; i++) push_word(DW'(8'h20 + i), 1);
        recv_data = 8'h30;
        recv_done = 1'b1;
        tick(1);
        tx_force = 1'b0; tx_auto = 1'b1; busy_len = 2;
        tick(1);
        recv_done = 1'b0;
        checks += 3;
        if (fifo_level !== 5'd16) begin errors++; $display("FAIL fullpop_level: got %0d, required 16", fifo_level); end
        if (overflow !== 1'b0) begin errors++; $display("FAIL fullpop_overflow: got %b, required 0", overflow); end
        if (send_en !== 1'b1 || send_data !== 8'h20) begin errors++; $display("FAIL fullpop_start: got en=%b data=%h, required en=1 data=20", send_en, send_data); end
        wait_pulses(17, 600, "fullpop");
        tick(20);
        checks++;
        if (pulse_cnt !== 17) begin errors++; $display("FAIL fullpop_pulses: got %0d, required 17", pulse_cnt); end
        for (int i = 0; i < 17 && i < sent_q.size(); i++) begin
            checks++;
            if (sent_q[i] !== DW'(8'h20 + i)) begin errors++; $display("FAIL fullpop_order[%0d]: got %h, required %h", i, sent_q[i], DW'(8'h20 + i)); end
        end
    endtask

    task automatic test_timeout();
        int k = 0;
        do_reset();
        push_word(8'h5C, 1);
        wait_pulses(1, 20, "timeout");
        while (tx_timeout !== 1'b1 && k < BT + 20) begin
            tick(1);
            k++;
        end
        checks++;
        if (cyc - pulse_cyc !== BT + 1) begin errors++; $display("FAIL timeout_latency: got %0d cycles after send_en, required %0d", cyc - pulse_cyc, BT + 1); end
        tick(20);
        checks += 3;
        if (pulse_cnt !== 1) begin errors++; $display("FAIL timeout_retry: got %0d pulses, required 1", pulse_cnt); end
        if (fifo_level !== 5'd0) begin errors++; $display("FAIL timeout_level: got %0d, required 0", fifo_level); end
        if (tx_timeout !== 1'b1) begin errors++; $display("FAIL timeout_sticky: got %b, required 1", tx_timeout); end
        clr_status = 1'b1;
        tick(1);
        clr_status = 1'b0;
        checks++;
        if (tx_timeout !== 1'b0) begin errors++; $display("FAIL timeout_clear: got %b, required 0", tx_timeout); end
    endtask

    task automatic test_echo_disable();
        do_reset();
        echo_en = 1'b0; tx_auto = 1'b1;
        for (int i = 0; i < 3; i++) push_word(DW'(8'h40 + i), 2);
        tick(10);
        echo_en = 1'b1;
        checks += 3;
        if (fifo_level !== 5'd0) begin errors++; $display("FAIL disable_level: got %0d, required 0", fifo_level); end
        if (pulse_cnt !== 0) begin errors++; $display("FAIL disable_pulses: got %0d, required 0", pulse_cnt); end
        if (overflow !== 1'b0) begin errors++; $display("FAIL disable_overflow: got %b, required 0", overflow); end
    endtask

    task automatic test_flush();
        do_reset();
        tx_auto = 1'b1; busy_len = 40;
        for (int i = 0; i < 6; i++) push_word(DW'(8'h60 + i), 1);
        tick(1);
        checks += 2;
        if (fifo_level !== 5'd5) begin errors++; $display("FAIL flush_pre_level: got %0d, required 5", fifo_level); end
        if (pulse_cnt !== 1) begin errors++; $display("FAIL flush_pre_pulses: got %0d, required 1", pulse_cnt); end
        flush = 1'b1;
        tick(1);
        flush = 1'b0;
        checks++;
        if (fifo_level !== 5'd0) begin errors++; $display("FAIL flush_level: got %0d, required 0", fifo_level); end
        tick(60);
        checks += 3;
        if (pulse_cnt !== 1) begin errors++; $display("FAIL flush_pulses: got %0d, required 1", pulse_cnt); end
        if (send_data !== 8'h60) begin errors++; $display("FAIL flush_hold_data: got %h, required 60", send_data); end
        if (fifo_level !== 5'd0) begin errors++; $display("FAIL flush_post_level: got %0d, required 0", fifo_level); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        tx_auto = 1'b1; busy_len = 40;
        for (int i = 0; i < 5; i++) push_word(DW'(8'h71 + i), 1);
        tick(1);
        checks++;
        if (fifo_level !== 5'd4) begin errors++; $display("FAIL rstmid_pre_level: got %0d, required 4", fifo_level); end
        sys_rst_n = 1'b0;
        #1;
        checks += 3;
        if (send_en !== 1'b0 || send_data !== 8'h00) begin errors++; $display("FAIL rstmid_tx: got en=%b data=%h, required 0/00", send_en, send_data); end
        if (fifo_level !== 5'd0) begin errors++; $display("FAIL rstmid_level: got %0d, required 0", fifo_level); end
        if (overflow !== 1'b0 || tx_timeout !== 1'b0) begin errors++; $display("FAIL rstmid_flags: got %b%b, required 00", overflow, tx_timeout); end
        tick(2);
        sys_rst_n = 1'b1;
        tick(60);
        checks += 2;
        if (pulse_cnt !== 1) begin errors++; $display("FAIL rstmid_pulses: got %0d, required 1", pulse_cnt); end
        if (fifo_level !== 5'd0) begin errors++; $display("FAIL rstmid_post_level: got %0d, required 0", fifo_level); end
    endtask

    task automatic test_random();
        logic [DW-1:0] exp_q[$];
        logic [DW-1:0] d;
        logic en;
        int n;
        for (int r = 0; r < 3; r++) begin
            do_reset();
            tx_auto = 1'b1;
            exp_q.delete();
            n = $urandom_range(4, 14);
            for (int i = 0; i < n; i++) begin
                busy_len = $urandom_range(1, 8);
                d = DW'($urandom);
                en = ($urandom_range(0, 3) != 0);
                echo_en = en;
                push_word(d, $urandom_range(1, 3));
                tick($urandom_range(0, 5));
                if (en) exp_q.push_back(d);
            end
            echo_en = 1'b1;
            wait_pulses(exp_q.size(), 1000, "random");
            tick(20);
            checks += 3;
            if (pulse_cnt !== exp_q.size()) begin errors++; $display("FAIL random_pulses: got %0d, required %0d", pulse_cnt, exp_q.size()); end
            if (overflow !== 1'b0) begin errors++; $display("FAIL random_overflow: got %b, required 0", overflow); end
            if (fifo_level !== 5'd0) begin errors++; $display("FAIL random_level: got %0d, required 0", fifo_level); end
            for (int i = 0; i < exp_q.size() && i < sent_q.size(); i++) begin
                checks++;
                if (sent_q[i] !== exp_q[i]) begin errors++; $display("FAIL random_data[%0d]: got %h, required %h", i, sent_q[i], exp_q[i]); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_echo();
        test_burst_full();
        test_full_pop();
        test_timeout();
        test_echo_disable();
        test_flush();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_echo_fifo.md
Name: uart_echo_fifo

Overview:
Parametrised UART echo engine. It sits between the UART receiver (recv_done/recv_data) and the UART transmitter (tx_busy/send_en/send_data).
- Detects receiver completion and buffers received words in a DEPTH-entry FIFO.
- Drains the FIFO to the transmitter through a handshake with the transmitter's busy signal.
- Bursts of back-to-back received bytes are not lost while the transmitter is busy.
- Adds echo enable, flush, overflow and handshake-timeout status.

Parameters:
DATA_W, 8, data word width in bits.
DEPTH, 16, FIFO entries; power of 2, at least 2.
BUSY_TIMEOUT, 64, cycles to wait for tx_busy to rise after send_en; at least 4.

Ports:
sys_clk  in  1  system clock, rising edge.
sys_rst_n  in  1  reset, asynchronous, active-low.
recv_done  in  1  receiver done, level/pulse; only its rising edge is used.
recv_data  in  DATA_W  received word, stable while recv_done is high.
tx_busy  in  1  transmitter busy.
echo_en  in  1  1 = push received words; 0 = discard them.
flush  in  1  synchronous FIFO clear, one cycle.
clr_status  in  1  clears the sticky overflow and tx_timeout flags.
send_en  out  1  one-cycle start pulse to the transmitter.
send_data  out  DATA_W  word being transmitted.
fifo_level  out  $clog2(DEPTH)+1  current FIFO occupancy, 0..DEPTH.
overflow  out  1  sticky: a word was dropped because the FIFO was full.
tx_timeout  out  1  sticky: tx_busy did not rise within BUSY_TIMEOUT cycles.

Behaviour:
- Reset (asynchronous): all of the following clear to 0:
  - outputs send_en, send_data, fifo_level, overflow, tx_timeout
  - internal sync flops and FIFO pointers
  - FSM goes to IDLE
  - FIFO RAM contents need not be reset
- Reset asserted mid-transfer aborts immediately; no send_en follows release.
- Edge detect:
  - recv_done passes through two flops, d0 then d1.
  - push_req = d0 & ~d1.
  - recv_data is sampled in the push_req cycle: 2 clocks after recv_done is first sampled high.
  - A recv_done held high produces exactly one push.
- Push: on push_req with echo_en=1.
  - Accepted if fifo_level<DEPTH, or if fifo_level==DEPTH and a pop occurs in the same cycle.
  - Otherwise the word is dropped and overflow is set.
  - echo_en=0: no push and no overflow.
- Pointers: address width log2(DEPTH); they wrap naturally.
- fifo_level update: +1 on push only, -1 on pop only, unchanged when both happen.
- flush:
  - Clears pointers and level next cycle; a push or pop in the same cycle is ignored.
  - Does not disturb an in-progress transfer: send_data is held and the FSM continues.
- Sticky flags:
  - overflow/tx_timeout set has priority over clr_status in the same cycle.
  - Otherwise clr_status clears both.
- TX FSM:
  - IDLE:
    - If fifo_level!=0 && !tx_busy && !flush: pop, register send_data<=head, go START.
    - Otherwise stay in IDLE.
  - START:
    - send_en=1 for exactly this cycle.
    - Clear the timeout counter and go WAIT_BUSY.
  - WAIT_BUSY:
    - tx_busy=1: go WAIT_IDLE.
    - Counter reaches BUSY_TIMEOUT-1: set tx_timeout, go IDLE; the word is discarded, not retried.
    - Otherwise increment the counter.
  - WAIT_IDLE:
    - tx_busy=0: go IDLE.
- send_en is registered and is 0 in every state except START.
- send_data is stable from the pop until the next pop.
- Minimum spacing between successive send_en pulses is 4 cycles: START, WAIT_BUSY, WAIT_IDLE, IDLE.
- The FIFO read is combinational from the head entry; a pop in IDLE makes the data valid in START.
- Empty FIFO: no pop and no send_en.
- A push into an empty FIFO can be popped at the earliest in the cycle after the push.

Test Plan:
1. Single echo: reset, echo_en=1, recv_data=8'hA5, recv_done high 3 cycles, tx model raises busy 2 cycles after send_en for 10 cycles -> one send_en pulse with send_data=8'hA5; fifo_level returns to 0; flags stay 0.
2. Burst/full: hold tx_busy=1, push 17 words 8'h00..8'h10 with DEPTH=16 -> fifo_level=16, overflow=1, 8'h10 dropped; release busy -> send_data sequence 8'h00..8'h0F in order, 16 send_en pulses.
3. Full plus simultaneous pop: FIFO full, push_req coincides with an IDLE pop -> word accepted, fifo_level stays 16, overflow stays 0.
4. Timeout: one word queued, tx_busy held 0 -> send_en once, tx_timeout=1 exactly BUSY_TIMEOUT cycles after WAIT_BUSY entry, no retry; clr_status -> tx_timeout=0.
5. Control inputs: echo_en=0 with 3 recv_done pulses -> fifo_level stays 0, no send_en. flush with 5 queued words during an active transfer -> fifo_level=0 next cycle, the current transfer completes, no further send_en.
6. Reset mid-operation: assert sys_rst_n=0 in WAIT_IDLE with 4 words queued -> all outputs 0 immediately; after release no send_en without a new recv_done.
